// File: rtl/axi_rd_n_merger_pkg.sv
// Shared definitions for the N-to-1 AXI read-channel merger: AXI response/burst
// codes, arbiter state encoding and width helpers.
package axi_rd_n_merger_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A single port still needs one index bit so rid slicing stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_n_merger_if.sv
// AXI read-channel bundle (AR + R), LANES channels packed side by side.
// The merger uses a LANES=NPORTS instance upstream and a LANES=1 instance downstream.
interface axi_rd_n_merger_if #(
  parameter int LANES = 1,
  parameter int IW    = 4,
  parameter int DW    = 64,
  parameter int EW    = 8
);
  import axi_rd_n_merger_pkg::*;

  logic [LANES*IW-1:0] arid;
  logic [LANES*32-1:0] araddr;
  logic [LANES*8-1:0]  arlen;
  logic [LANES*EW-1:0] arextras;
  logic [LANES*2-1:0]  arburst;
  logic [LANES-1:0]    arvalid;
  logic [LANES-1:0]    arready;
  logic [LANES*IW-1:0] rid;
  logic [LANES*DW-1:0] rdata;
  logic [LANES*2-1:0]  rresp;
  logic [LANES-1:0]    rlast;
  logic [LANES-1:0]    rvalid;
  logic [LANES-1:0]    rready;

  modport master (
    output arid, araddr, arlen, arextras, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arextras, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_n_merger_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; on advance the pointer moves to one past the current grant.
module rr_arbiter
  import axi_rd_n_merger_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_bin
);

  logic [W-1:0] ptr;

  always_comb begin
    int   cand;
    logic found;
    cand      = 0;
    found     = 1'b0;
    grant_oh  = '0;
    grant_bin = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_bin      = W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_bin) == N - 1) ? '0 : grant_bin + 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_n_merger.sv
// N-to-1 AXI read merger: per-port AR FIFOs, round-robin AR issue with the port
// index prepended to ARID, combinational R return. Optional bad-beat checking under
// AXI_RD_MERGER_ERR_CHECK_EN (sinks bad beats and raises sticky rd_err).
module axi_rd_n_merger
  import axi_rd_n_merger_pkg::*;
#(
  parameter  int NPORTS           = 4,
  parameter  int IDWID            = 4,
  parameter  int DWID             = 64,
  parameter  int EXTRAS           = 8,
  parameter  int AFIFO_DEPTH_LOG2 = 2,
  parameter  int MAXOUT           = 8,
  localparam int PW               = idx_width(NPORTS)
) (
  input  logic                clk,
  input  logic                rst,
  axi_rd_n_merger_if.slave    s,
  axi_rd_n_merger_if.master   m,
  output logic                rd_err
);

  localparam int DEPTH = 1 << AFIFO_DEPTH_LOG2;
  localparam int AL    = AFIFO_DEPTH_LOG2;
  localparam int ARW   = IDWID + 32 + 8 + EXTRAS + 2;
  localparam int CW    = clog2(MAXOUT + 1);

  logic [NPORTS-1:0] fifo_empty;
  logic [NPORTS-1:0] fifo_full;
  logic [NPORTS-1:0] elig;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] dec;
  logic [NPORTS-1:0] cnt_zero;
  logic [NPORTS-1:0] r_hit;
  logic [NPORTS-1:0] r_gate;
  logic [ARW-1:0]    head   [NPORTS];
  logic [CW-1:0]     outst  [NPORTS];

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     grant_q;
  logic [NPORTS-1:0] grant_oh_q;
  logic [NPORTS-1:0] arb_req;
  logic [NPORTS-1:0] arb_oh;
  logic [PW-1:0]     arb_bin;
  logic              ar_fire;
  logic [PW-1:0]     r_idx;
  logic [IDWID-1:0]  head_id;

  assign s.arready = ~fifo_full;
  assign ar_fire   = m.arvalid[0] & m.arready[0];
  assign pop       = {NPORTS{ar_fire}} & grant_oh_q;
  assign r_idx     = m.rid[IDWID +: PW];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [ARW-1:0] mem [DEPTH];
    logic [AL:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt_q;
    logic           push;
    logic           inc;

    assign push = s.arvalid[p] & ~fifo_full[p];
    assign inc  = pop[p];

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[AL-1:0]] <= {s.arid[p*IDWID +: IDWID], s.araddr[p*32 +: 32],
                                s.arlen[p*8 +: 8], s.arextras[p*EXTRAS +: EXTRAS],
                                s.arburst[p*2 +: 2]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop[p]) rd_ptr <= rd_ptr + 1'b1;
      end
    end

    assign fifo_empty[p] = (wr_ptr == rd_ptr);
    assign fifo_full[p]  = (wr_ptr[AL] != rd_ptr[AL]) && (wr_ptr[AL-1:0] == rd_ptr[AL-1:0]);
    assign head[p]       = mem[rd_ptr[AL-1:0]];

    // Increment and decrement in the same cycle cancel out.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (inc && !dec[p]) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec[p] && !inc) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    assign outst[p]    = cnt_q;
    assign cnt_zero[p] = (cnt_q == '0);
    assign elig[p]     = !fifo_empty[p] && (cnt_q < CW'(MAXOUT));
    assign r_hit[p]    = (r_idx == PW'(p));
    assign dec[p]      = s.rvalid[p] & s.rready[p] & m.rlast[0] & ~cnt_zero[p];
  end

  // While locked only the granted port requests, so the arbiter's grant equals
  // grant_q and advance moves the pointer to one past it.
  assign arb_req = (state_q == ST_IDLE) ? elig : grant_oh_q;

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .advance   (ar_fire),
    .grant_oh  (arb_oh),
    .grant_bin (arb_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && |elig) begin
        grant_q    <= arb_bin;
        grant_oh_q <= arb_oh;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|elig)   state_d = ST_LOCKED;
      ST_LOCKED: if (ar_fire) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // The FIFO head cannot move while locked, so the AR fields stay stable.
  always_comb begin
    head_id    = '0;
    m.arvalid  = 1'b0;
    m.arid     = '0;
    m.araddr   = '0;
    m.arlen    = '0;
    m.arextras = '0;
    m.arburst  = '0;
    if (state_q == ST_LOCKED) begin
      m.arvalid = 1'b1;
      {head_id, m.araddr, m.arlen, m.arextras, m.arburst} = head[grant_q];
      m.arid = {grant_q, head_id};
    end
  end

  assign s.rid    = {NPORTS{m.rid[IDWID-1:0]}};
  assign s.rdata  = {NPORTS{m.rdata}};
  assign s.rresp  = {NPORTS{m.rresp}};
  assign s.rlast  = {NPORTS{m.rlast[0]}};
  assign s.rvalid = {NPORTS{m.rvalid[0]}} & r_hit & r_gate;

`ifdef AXI_RD_MERGER_ERR_CHECK_EN
  logic r_bad;
  logic rd_err_q;

  // Beats for an unknown port or a port with nothing outstanding are swallowed.
  assign r_bad     = ~|r_hit | |(r_hit & cnt_zero);
  assign r_gate    = ~cnt_zero;
  assign m.rready  = r_bad | |(r_hit & s.rready);
  assign rd_err    = rd_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err_q <= 1'b0;
    end else if (m.rvalid[0] && r_bad) begin
      rd_err_q <= 1'b1;
    end
  end
`else
  assign r_gate    = '1;
  assign m.rready  = |(r_hit & s.rready);
  assign rd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_n_merger.sv
// Self-checking bench for axi_rd_n_merger: AR expectations queued on push and
// matched per port when the downstream AR fires; R beats checked as presented.
module tb_axi_rd_n_merger;
  import axi_rd_n_merger_pkg::*;

  localparam int NPORTS           = 4;
  localparam int IDWID            = 4;
  localparam int DWID             = 64;
  localparam int EXTRAS           = 8;
  localparam int AFIFO_DEPTH_LOG2 = 2;
  localparam int MAXOUT           = 8;
  localparam int PW               = idx_width(NPORTS);
  localparam int ARW              = PW + IDWID + 32 + 8 + EXTRAS + 2;

  typedef struct {
    int             port;
    logic [ARW-1:0] word;
  } ar_exp_t;

  typedef struct {
    logic [NPORTS-1:0] rvalid;
    logic [IDWID-1:0]  id;
    logic [DWID-1:0]   data;
    logic              last;
    logic              rready;
  } r_exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    rd_err;
  int      n_compared   = 0;
  int      n_mismatched = 0;
  int      ar_count     = 0;
  ar_exp_t ar_q[$];
  int      order_q[$];
  r_exp_t  r_q[$];

  axi_rd_n_merger_if #(.LANES(NPORTS), .IW(IDWID), .DW(DWID), .EW(EXTRAS)) s_if ();
  axi_rd_n_merger_if #(.LANES(1), .IW(IDWID + PW), .DW(DWID), .EW(EXTRAS)) m_if ();

  axi_rd_n_merger #(
    .NPORTS(NPORTS), .IDWID(IDWID), .DWID(DWID), .EXTRAS(EXTRAS),
    .AFIFO_DEPTH_LOG2(AFIFO_DEPTH_LOG2), .MAXOUT(MAXOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s      (s_if),
    .m      (m_if),
    .rd_err (rd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [ARW-1:0] mkWord(input int p, input int id, input logic [31:0] addr, input logic [7:0] len);
    logic [7:0] ext;
    ext = addr[7:0] ^ 8'h5a;
    return {PW'(p), IDWID'(id), addr, len, ext, BURST_INCR};
  endfunction

  // Downstream AR monitor: match each fired AR to the oldest pending one of its port.
  initial begin
    int             mon_port;
    int             mon_idx;
    logic [ARW-1:0] mon_obs;
    forever begin
      @(negedge clk);
      if (!rst && m_if.arvalid[0] && m_if.arready[0]) begin
        mon_obs  = {m_if.arid, m_if.araddr, m_if.arlen, m_if.arextras, m_if.arburst};
        mon_port = int'(m_if.arid[IDWID +: PW]);
        mon_idx  = -1;
        for (int i = 0; i < ar_q.size(); i++)
          if (mon_idx < 0 && ar_q[i].port == mon_port) mon_idx = i;
        checkOutput("ar_expected", 128'(mon_idx >= 0), 128'(1));
        if (mon_idx >= 0) begin
          checkOutput("ar_fields", mon_obs, ar_q[mon_idx].word);
          ar_q.delete(mon_idx);
        end
        if (order_q.size() > 0) checkOutput("ar_order", mon_port, order_q.pop_front());
        ar_count++;
      end
    end
  end

  task automatic applyReset();
    rst           = 1'b1;
    s_if.arvalid  = '0;
    s_if.arid     = '0;
    s_if.araddr   = '0;
    s_if.arlen    = '0;
    s_if.arextras = '0;
    s_if.arburst  = '0;
    s_if.rready   = '0;
    m_if.arready  = '0;
    m_if.rvalid   = '0;
    m_if.rid      = '0;
    m_if.rdata    = '0;
    m_if.rresp    = '0;
    m_if.rlast    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ar_q.delete();
    order_q.delete();
    ar_count = 0;
    @(negedge clk);
    checkOutput("rst_arready", s_if.arready, {NPORTS{1'b1}});
    checkOutput("rst_arvalid", m_if.arvalid, 0);
    checkOutput("rst_rready", m_if.rready, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    for (int p = 0; p < NPORTS; p++) checkOutput("rst_outst", dut.outst[p], 0);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input int id, input logic [31:0] addr, input logic [7:0] len);
    logic accepted;
    s_if.arid[p*IDWID +: IDWID]      = IDWID'(id);
    s_if.araddr[p*32 +: 32]          = addr;
    s_if.arlen[p*8 +: 8]             = len;
    s_if.arextras[p*EXTRAS +: EXTRAS] = addr[7:0] ^ 8'h5a;
    s_if.arburst[p*2 +: 2]           = BURST_INCR;
    s_if.arvalid[p]                  = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (s_if.arready[p]) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    s_if.arvalid[p] = 1'b0;
    checkOutput("ar_push_accept", accepted, 1);
    if (accepted) ar_q.push_back('{p, mkWord(p, id, addr, len)});
  endtask

  task automatic waitArCount(input int target);
    int budget;
    budget = 200;
    while (ar_count < target && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("ar_count", ar_count, target);
  endtask

  task automatic sendBeat(input int port, input int id, input logic [DWID-1:0] data, input logic last,
                          input logic [NPORTS-1:0] exp_rvalid, input logic exp_rready);
    r_exp_t e;
    m_if.rid    = {PW'(port), IDWID'(id)};
    m_if.rdata  = data;
    m_if.rresp  = RESP_OKAY;
    m_if.rlast  = last;
    m_if.rvalid = 1'b1;
    r_q.push_back('{exp_rvalid, IDWID'(id), data, last, exp_rready});
    @(negedge clk);
    e = r_q.pop_front();
    checkOutput("r_valid", s_if.rvalid, e.rvalid);
    if (e.rvalid != '0) begin
      checkOutput("r_id", s_if.rid[port*IDWID +: IDWID], e.id);
      checkOutput("r_data", s_if.rdata[port*DWID +: DWID], e.data);
      checkOutput("r_last", s_if.rlast[port], e.last);
    end
    checkOutput("r_ready", m_if.rready, e.rready);
    @(posedge clk);
    #1;
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
  endtask

  initial begin
    logic seen;
    applyReset();

    // Round robin: all four ports load at once, issue order 0,1,2,3.
    for (int p = 0; p < NPORTS; p++) begin
      s_if.arid[p*IDWID +: IDWID]       = IDWID'(p + 1);
      s_if.araddr[p*32 +: 32]           = 32'h100 * (p + 1);
      s_if.arlen[p*8 +: 8]              = 8'(p);
      s_if.arextras[p*EXTRAS +: EXTRAS] = 8'(32'h100 * (p + 1)) ^ 8'h5a;
      s_if.arburst[p*2 +: 2]            = BURST_INCR;
    end
    s_if.arvalid = '1;
    @(negedge clk);
    checkOutput("rr_arready", s_if.arready, {NPORTS{1'b1}});
    @(posedge clk);
    #1;
    s_if.arvalid = '0;
    for (int p = 0; p < NPORTS; p++) begin
      ar_q.push_back('{p, mkWord(p, p + 1, 32'h100 * (p + 1), 8'(p))});
      order_q.push_back(p);
    end
    m_if.arready = 1'b1;
    waitArCount(4);
    for (int p = 0; p < NPORTS; p++) checkOutput("rr_outst", dut.outst[p], 1);
    checkOutput("rr_ptr_wrap", dut.u_arb.ptr, 0);

    // Stall: AR held with arready low for 5 cycles.
    m_if.arready = 1'b0;
    applyStimulus(1, 9, 32'hA000_1000, 8'd3);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_if.arvalid[0]) seen = 1'b1;
    end
    checkOutput("stall_arvalid_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_hold",
                  {m_if.arvalid, m_if.arid, m_if.araddr, m_if.arlen, m_if.arextras, m_if.arburst},
                  {1'b1, mkWord(1, 9, 32'hA000_1000, 8'd3)});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_if.arready = 1'b1;
    waitArCount(5);
    checkOutput("stall_rr_ptr", dut.u_arb.ptr, 2);
    checkOutput("stall_outst1", dut.outst[1], 2);
    repeat (3) @(negedge clk);
    checkOutput("stall_single_pop", m_if.arvalid, 0);

    // Interleaved R beats for ports 3 and 0.
    @(posedge clk);
    #1;
    s_if.rready = '1;
    for (int k = 0; k < 4; k++) begin
      sendBeat(3, 7, 64'h3000 + 64'(k), k == 3, 4'b1000, 1'b1);
      if (k == 0) checkOutput("il_outst3_mid", dut.outst[3], 1);
      sendBeat(0, 5, 64'h0500 + 64'(k), k == 3, 4'b0001, 1'b1);
    end
    checkOutput("il_outst3_end", dut.outst[3], 0);
    checkOutput("il_outst0_end", dut.outst[0], 0);

    // Port-1 beat blocked by its own rready.
    s_if.rready = 4'b1101;
    m_if.rid    = {PW'(1), 4'd2};
    m_if.rdata  = 64'hDEAD_BEEF;
    m_if.rlast  = 1'b1;
    m_if.rvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("held_rready", m_if.rready, 0);
      checkOutput("held_rvalid", s_if.rvalid, 4'b0010);
      @(posedge clk);
      #1;
    end
    checkOutput("held_outst1", dut.outst[1], 2);
    checkOutput("held_outst0", dut.outst[0], 0);
    s_if.rready = '1;
    @(negedge clk);
    checkOutput("release_rready", m_if.rready, 1);
    @(posedge clk);
    #1;
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    checkOutput("release_outst1", dut.outst[1], 1);

    // MAXOUT throttling on port 2; port 0 keeps flowing.
    applyReset();
    m_if.arready = 1'b1;
    s_if.rready  = '1;
    for (int k = 0; k < 9; k++) applyStimulus(2, k, 32'h2000_0000 + 32'(k * 64), 8'd0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("maxout_issued", ar_count, 8);
    checkOutput("maxout_outst2", dut.outst[2], MAXOUT);
    applyStimulus(0, 3, 32'h0000_4000, 8'd1);
    waitArCount(9);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("maxout_still_held", ar_count, 9);
    sendBeat(2, 0, 64'h2222, 1'b1, 4'b0100, 1'b1);
    waitArCount(10);
    checkOutput("maxout_outst2_after", dut.outst[2], MAXOUT);

`ifdef AXI_RD_MERGER_ERR_CHECK_EN
    sendBeat(1, 0, 64'hBAD, 1'b1, 4'b0000, 1'b1);
    checkOutput("err_rd_err_set", rd_err, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_rd_err_sticky", rd_err, 1);
`else
    sendBeat(1, 0, 64'hBAD, 1'b1, 4'b0010, 1'b1);
    checkOutput("noerr_rd_err", rd_err, 0);
    checkOutput("noerr_outst1", dut.outst[1], 0);
`endif

    applyReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/axi_rd_n_merger.md
Name: axi_rd_n_merger

Overview:
- Parametrised N-to-1 AXI read-channel merger for the axi_noc fabric.
- Each slave port has an AR FIFO. A round-robin arbiter picks one port for the single downstream master.
- Downstream ARID = {port_index, original_id}, so R beats route back by decoding the rid upper bits. No per-port ID FIFOs.
- Per-port outstanding-burst counters throttle each port independently.

Parameters:
- NPORTS, 4, number of upstream slave ports (2..16).
- IDWID, 4, upstream ID width.
- DWID, 64, data width.
- EXTRAS, 8, sideband bits carried with AR.
- AFIFO_DEPTH_LOG2, 2, per-port AR FIFO depth = 2**AFIFO_DEPTH_LOG2.
- MAXOUT, 8, maximum outstanding read bursts per port (1..255).
- PW, derived: max(1, clog2(NPORTS)), port-index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_arid  in  NPORTS*IDWID  per-port ARID, port p at slice [p*IDWID +: IDWID]; all s_* vectors slice the same way
- s_araddr  in  NPORTS*32  address
- s_arlen  in  NPORTS*8  burst length
- s_arextras  in  NPORTS*EXTRAS  sideband
- s_arburst  in  NPORTS*2  burst type
- s_arvalid  in  NPORTS  AR valid
- s_arready  out  NPORTS  = !fifo_full[p]
- s_rid  out  NPORTS*IDWID  rid[IDWID-1:0], broadcast
- s_rdata  out  NPORTS*DWID  rdata, broadcast
- s_rresp  out  NPORTS*2  rresp, broadcast
- s_rlast  out  NPORTS  rlast, broadcast
- s_rvalid  out  NPORTS  rvalid && (rid[IDWID+:PW]==p)
- s_rready  in  NPORTS  per-port R ready
- arid  out  IDWID+PW  {grant_idx, original arid}
- araddr  out  32
- arlen  out  8
- arextras  out  EXTRAS
- arburst  out  2
- arvalid  out  1
- arready  in  1
- rid  in  IDWID+PW
- rdata  in  DWID
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1  = s_rready[rid[IDWID+:PW]], 0 if index ≥ NPORTS
- rd_err  out  1  sticky error (see Optional Feature); tied 0 when the feature is compiled out

Behaviour:
- Reset (rst high on a clk edge):
  - FIFOs emptied, outstanding counters cleared, rr pointer = 0, grant lock cleared.
  - All outputs 0 except s_arready = all ones once FIFOs are empty.
  - Reset mid-burst drops all in-flight state. The downstream is required to be reset together with this block.
- AR ingress: push on s_arvalid[p] && s_arready[p]. FIFO is first-word-fall-through. AR upstream→downstream latency ≥1 cycle.
- Eligibility: elig[p] = !fifo_empty[p] && (outst[p] < MAXOUT).
- Arbitration (IDLE/LOCKED state machine):
  - IDLE: if any elig, grant = first elig at or after rr_ptr (wrapping); go LOCKED.
  - LOCKED: arvalid = 1, AR fields come from the granted FIFO head. Grant and fields are held stable until arready.
  - On arvalid && arready: pop that FIFO, outst[grant]++, rr_ptr = grant+1 mod NPORTS, return to IDLE.
  - One AR is issued per 2 cycles at most.
- Counters: decrement on rvalid && rready && rlast for the decoded port. Simultaneous increment and decrement on the same port leaves the counter unchanged.
  - Counter width = clog2(MAXOUT+1).
  - Never exceeds MAXOUT: the eligibility gate is evaluated at grant time, and the count cannot change while LOCKED except by decrement.
- R path: purely combinational, zero latency. Beats of different ports may interleave as the downstream delivers them.
- Full/empty:
  - FIFO full → s_arready[p] = 0.
  - Port at MAXOUT is skipped by the arbiter; other ports continue without stall.

Optional Feature:
- Macro: AXI_RD_MERGER_ERR_CHECK_EN.
- Defined:
  - An R beat is "bad" if its decoded index ≥ NPORTS or outst[idx] == 0.
  - A bad beat is sunk: rready = 1, no s_rvalid asserted, rd_err set sticky until rst.
- Not defined: no check; rready = 0 for out-of-range index; rd_err tied 0.

Decomposition:
- Shared include axi_noc_defs.vh: RESP_OKAY/EXOKAY/SLVERR/DECERR codes, BURST_FIXED/INCR/WRAP codes, clog2 function.
- Sub-module rr_arbiter #(N): inputs req, advance; outputs one-hot and binary grant; holds the rotating pointer.
- AR FIFOs reuse the existing syncfifo.

Test Plan:
- NPORTS=4, ports 0..3 each push one AR (ids 1,2,3,4), arready=1 → downstream arids {0,1},{1,2},{2,3},{3,4} in round-robin order; counters become 1,1,1,1.
- Port 2 pushes 9 ARs with MAXOUT=8 and no R returned → exactly 8 issued; the 9th stays until one rlast on rid={2,x}, then issues.
- arready held 0 for 5 cycles with grant=1 → arvalid and all AR fields stable for 5 cycles; after arready, port 1 FIFO pops once and rr_ptr=2.
- Interleaved R beats rid={3,7} and {0,5}, arlen=3 → s_rvalid[3]/s_rvalid[0] follow the rid; s_rid=7/5; counters decrement only on rlast.
- s_rready[1]=0 while a port-1 beat is presented → rready=0 and the beat is held; port 0 counter unaffected.
- With AXI_RD_MERGER_ERR_CHECK_EN: rid={1,0} while outst[1]=0 → rready=1, no s_rvalid, rd_err=1 until rst.
